lamp_fpu_sqrt_sched: RTL
========================

Name: lamp_fpu_sqrt_sched

Overview:
Scheduler that shares one lampFPU_sqrt datapath (sqrt / inverse sqrt) between NUM_REQ requesters.
- Arbitrates incoming operand requests round-robin and drives the datapath's operand/flag inputs and doSqrt pulse.
- Holds operands stable until the datapath reports valid, then returns the tagged result through a valid/ready response port.
- One operation in flight at a time. Sits between the FPU issue logic and lampFPU_sqrt.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, $clog2(NUM_REQ) (min 1), response tag width
MAX_LAT, 32, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
req_inv_i  in  NUM_REQ  1 = inverse sqrt
req_sign_i  in  NUM_REQ  operand sign
req_exp_i  in  NUM_REQ*8  extended exponents, requester i at [8i+:8]
req_mant_i  in  NUM_REQ*8  extended mantissas (hidden bit + 7), [8i+:8]
req_flags_i  in  NUM_REQ*4  {isInf,isZero,isSNAN,isQNAN}, [4i+:4]
sq_do_o  out  1  doSqrt pulse to datapath
sq_inv_o, sq_sign_o, sq_isInf_o, sq_isZero_o, sq_isSNAN_o, sq_isQNAN_o  out  1 each  held operand fields
sq_exp_o  out  8  held exponent
sq_mant_o  out  8  held mantissa
sq_valid_i  in  1  datapath result valid
sq_s_i  in  1  result sign
sq_e_i  in  8  result exponent
sq_f_i  in  12  result significand
sq_round_i  in  1  datapath isToRound
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_id_o  out  ID_W  index of the requester served
rsp_s_o  out  1  result sign
rsp_e_o  out  8  result exponent
rsp_f_o  out  12  result significand
rsp_round_o  out  1  result needs rounding
rsp_err_o  out  1  watchdog abort flag
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, rr pointer 0. All outputs 0, all held operand and result registers 0.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant = first i with req_valid_i[i], scanning from the rr pointer upward with wrap. req_ready_o[grant]=1 combinationally.
  - On the handshake: latch that requester's fields and id; pointer <= (grant+1) mod NUM_REQ; go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: sq_do_o=1 for exactly one cycle; go to WAIT.
- WAIT: sq_do_o=0. On sq_valid_i=1, capture sq_s/e/f/round into the result register and go to RESP.
- sq_valid_i is ignored in IDLE, ISSUE and RESP (stale or late pulses are dropped).
- RESP: rsp_valid_o=1 with stable fields until rsp_ready_i=1. On the handshake go to IDLE.
  - No new grant in the handshake cycle; the earliest next req_ready_o is the following cycle.
- sq_* operand outputs stay constant from ISSUE through the end of WAIT. The datapath evaluates special cases from live inputs.
- Minimum latency, request handshake to rsp_valid_o: 2 + datapath latency + 1 cycles.
- Requesters must hold their fields while valid and not ready. Deasserting valid before ready is permitted and cancels that request.
- rsp_err_o = 0 unless the watchdog fires.
- Reset mid-operation: immediate return to IDLE. The in-flight result is discarded and no response is produced.

Optional Feature:
LAMP_SQRT_WATCHDOG_EN
- Defined:
  - Counter cleared on entering WAIT, incremented each WAIT cycle.
  - When the count reaches MAX_LAT without sq_valid_i, go to RESP with s=0, e=8'hFF, f=12'h800 (qNaN, bit 11 set) and round=0.
  - rsp_err_o=1 for that response.
  - If sq_valid_i and the limit coincide, the valid result wins and rsp_err_o=0.
- Undefined: no counter logic; rsp_err_o tied 0; WAIT has no time limit.

Decomposition:
- lampFPU_pkg gets:
  - state enum lampSqrtSchedState_t {IDLE, ISSUE, WAIT, RESP}
  - packed struct lampSqrtOp_t {inv, sign, exp[8], mant[8], isInf, isZero, isSNAN, isQNAN}
  - packed struct lampSqrtRes_t {s, e[8], f[12], round}
  - constant SQRT_WDOG_QNAN_F = 12'h800
- One sub-module: lamp_fpu_rr_arb (NUM_REQ; inputs req vector, pointer; output one-hot grant plus index).

Test Plan:
- Single request: req0 sqrt of 4.0 (exp 8'h81, mant 8'h80) with a 5-cycle datapath model. Expect one sq_do_o pulse the cycle after accept, operands stable through WAIT, and rsp_valid_o 8 cycles after accept with rsp_id_o=0.
- Contention: req0 and req1 valid continuously. Grants alternate 0,1,0,1 and rsp_id_o matches the grant order; verify the pointer wraps with NUM_REQ=3.
- Backpressure: rsp_ready_i held 0 for 10 cycles in RESP. Expect response fields unchanged, no req_ready_o asserted and no sq_do_o pulses, then IDLE after ready.
- Stray valid: sq_valid_i pulsed in IDLE and in ISSUE. Expect no response or state change from those pulses.
- Async reset: assert rst=0 during WAIT. Expect all outputs 0 immediately, and no response after release even when sq_valid_i arrives.
- Watchdog (macro defined, MAX_LAT=4): sq_valid_i never asserted. Expect rsp_valid_o with e=8'hFF, f=12'h800, rsp_err_o=1 after 4 WAIT cycles.

Source files
------------

// File: rtl/lamp_fpu_sqrt_sched_pkg.sv
// lamp_fpu_sqrt_sched_pkg: shared types and constants for the lampFPU sqrt
// scheduler. Provides the FSM state enum, the held-operand and result structs,
// and the qNaN pattern used when the optional watchdog
// (LAMP_SQRT_WATCHDOG_EN) aborts an operation.
package lamp_fpu_sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lampSqrtSchedState_t;

  typedef struct packed {
    logic       inv;
    logic       sign;
    logic [7:0] exp;
    logic [7:0] mant;
    logic       isInf;
    logic       isZero;
    logic       isSNAN;
    logic       isQNAN;
  } lampSqrtOp_t;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [11:0] f;
    logic        round;
  } lampSqrtRes_t;

  localparam logic [11:0] SQRT_WDOG_QNAN_F = 12'h800;
  localparam logic [7:0]  SQRT_WDOG_QNAN_E = 8'hFF;

endpackage

// File: rtl/lamp_fpu_sqrt_sched_if.sv
// lamp_fpu_sqrt_sched_if: tagged response channel of the sqrt scheduler.
//   rsp_valid / rsp_ready : valid/ready handshake
//   rsp_id                : index of the requester served (ID_W bits)
//   rsp_s/e/f/round       : result sign, exponent, significand, isToRound
//   rsp_err               : watchdog abort flag
// master = scheduler side, slave = consumer side.
interface lamp_fpu_sqrt_sched_if
  import lamp_fpu_sqrt_sched_pkg::*;
#(
  parameter int unsigned ID_W = 1
);
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_s;
  logic [7:0]      rsp_e;
  logic [11:0]     rsp_f;
  logic            rsp_round;
  logic            rsp_err;

  modport master (
    output rsp_valid, rsp_id, rsp_s, rsp_e, rsp_f, rsp_round, rsp_err,
    input  rsp_ready
  );

  modport slave (
    input  rsp_valid, rsp_id, rsp_s, rsp_e, rsp_f, rsp_round, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/lamp_fpu_sqrt_sched_rr_arb.sv
// lamp_fpu_rr_arb: combinational round-robin arbiter.
//   req_i  : request vector (NUM_REQ)
//   ptr_i  : index with highest priority; scan proceeds upward with wrap
//   gnt_o  : one-hot grant (zero when no request)
//   idx_o  : index of the granted requester
//   any_o  : at least one request present
module lamp_fpu_rr_arb
  import lamp_fpu_sqrt_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic found;

  // Outer loop walks priority distance from the pointer; the first requester
  // at the smallest distance wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] &&
            (((i + NUM_REQ - 32'(ptr_i)) % NUM_REQ) == k)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = ID_W'(i);
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/lamp_fpu_sqrt_sched.sv
// lamp_fpu_sqrt_sched: shares one lampFPU_sqrt datapath between NUM_REQ
// requesters. Round-robin grant in IDLE, one doSqrt pulse in ISSUE, operands
// held through WAIT, tagged result returned on the rsp interface in RESP.
// Ports:
//   clk, rst (async, active-low)
//   req_*  : per-requester valid/ready and operand fields (packed vectors)
//   sq_*   : datapath operand/doSqrt outputs and result inputs
//   rsp    : response channel (lamp_fpu_sqrt_sched_if.master)
//   busy_o : FSM not in IDLE
// Optional feature macro: LAMP_SQRT_WATCHDOG_EN (WAIT time limit of MAX_LAT
// cycles, aborts with a qNaN result and rsp_err=1).
module lamp_fpu_sqrt_sched
  import lamp_fpu_sqrt_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned MAX_LAT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ-1:0]     req_inv_i,
  input  logic [NUM_REQ-1:0]     req_sign_i,
  input  logic [NUM_REQ*8-1:0]   req_exp_i,
  input  logic [NUM_REQ*8-1:0]   req_mant_i,
  input  logic [NUM_REQ*4-1:0]   req_flags_i,
  output logic                   sq_do_o,
  output logic                   sq_inv_o,
  output logic                   sq_sign_o,
  output logic                   sq_isInf_o,
  output logic                   sq_isZero_o,
  output logic                   sq_isSNAN_o,
  output logic                   sq_isQNAN_o,
  output logic [7:0]             sq_exp_o,
  output logic [7:0]             sq_mant_o,
  input  logic                   sq_valid_i,
  input  logic                   sq_s_i,
  input  logic [7:0]             sq_e_i,
  input  logic [11:0]            sq_f_i,
  input  logic                   sq_round_i,
  lamp_fpu_sqrt_sched_if.master  rsp,
  output logic                   busy_o
);

  lampSqrtSchedState_t state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     id_q, id_d;
  lampSqrtOp_t         op_q, op_d, sel_op;
  lampSqrtRes_t        res_q, res_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic                wd_fire;
  logic                rsp_err_w;

  lamp_fpu_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op.inv    = req_inv_i[i];
        sel_op.sign   = req_sign_i[i];
        sel_op.exp    = req_exp_i[8*i +: 8];
        sel_op.mant   = req_mant_i[8*i +: 8];
        sel_op.isInf  = req_flags_i[4*i + 3];
        sel_op.isZero = req_flags_i[4*i + 2];
        sel_op.isSNAN = req_flags_i[4*i + 1];
        sel_op.isQNAN = req_flags_i[4*i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic; sq_valid_i only has effect in WAIT
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = ISSUE;
          id_d    = gnt_idx;
          op_d    = sel_op;
          rr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sq_valid_i) begin
          res_d.s     = sq_s_i;
          res_d.e     = sq_e_i;
          res_d.f     = sq_f_i;
          res_d.round = sq_round_i;
          state_d     = RESP;
        end else if (wd_fire) begin
          res_d.s     = 1'b0;
          res_d.e     = SQRT_WDOG_QNAN_E;
          res_d.f     = SQRT_WDOG_QNAN_F;
          res_d.round = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; ready is also gated by rst so nothing is granted during reset
  always_comb begin
    req_ready_o   = (state_q == IDLE && rst) ? gnt : '0;
    sq_do_o       = (state_q == ISSUE);
    busy_o        = (state_q != IDLE);
    rsp.rsp_valid = (state_q == RESP);
    rsp.rsp_id    = id_q;
    rsp.rsp_s     = res_q.s;
    rsp.rsp_e     = res_q.e;
    rsp.rsp_f     = res_q.f;
    rsp.rsp_round = res_q.round;
    rsp.rsp_err   = rsp_err_w;
  end

  assign sq_inv_o    = op_q.inv;
  assign sq_sign_o   = op_q.sign;
  assign sq_exp_o    = op_q.exp;
  assign sq_mant_o   = op_q.mant;
  assign sq_isInf_o  = op_q.isInf;
  assign sq_isZero_o = op_q.isZero;
  assign sq_isSNAN_o = op_q.isSNAN;
  assign sq_isQNAN_o = op_q.isQNAN;

`ifdef LAMP_SQRT_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             err_q, err_d;

  // Counter is zero outside WAIT, so it starts cleared on every WAIT entry.
  // A valid result in the limit cycle takes priority over the abort.
  always_comb begin
    wd_cnt_d = (state_q == WAIT) ? wd_cnt_q + CNT_W'(1) : '0;
    wd_fire  = (state_q == WAIT) && (wd_cnt_q == CNT_W'(MAX_LAT - 1));
    err_d    = err_q;
    if (state_q == WAIT && sq_valid_i)          err_d = 1'b0;
    else if (wd_fire)                           err_d = 1'b1;
    else if (state_q == RESP && rsp.rsp_ready)  err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign rsp_err_w = err_q;
`else
  logic [31:0] unused_max_lat;
  assign unused_max_lat = 32'(MAX_LAT);
  assign wd_fire        = 1'b0;
  assign rsp_err_w      = 1'b0;
`endif

endmodule
